// File: rtl/wb_arbiter_pkg.sv
// Types and helpers shared by the writeback arbiter and its source FIFOs.
// Latency: n/a (declarations only).
// Backpressure: n/a.
`include "defines.sv"

package wb_arbiter_pkg;

    localparam int PREG_W     = `PREG_LENGTH;
    localparam int WB_NSRC    = `WB_NSRC;
    localparam int WB_SRC_ALU = `WB_SRC_ALU;
    localparam int WB_SRC_MUL = `WB_SRC_MUL;
    localparam int WB_SRC_LSU = `WB_SRC_LSU;

    // One buffered writeback result.
    typedef struct packed {
        logic [PREG_W-1:0] pdst;
        logic [63:0]       data;
    } wb_entry_t;

    // (base + offset) mod 3 over the three source indices.
    function automatic logic [1:0] src_add(input logic [1:0] base, input int unsigned offset);
        int unsigned sum;
        sum = (int'(base) + offset) % 3;
        return sum[1:0];
    endfunction

endpackage

// File: rtl/defines.sv
// Shared register-file and writeback-source constants.
// Latency: n/a (compile-time constants only).
// Backpressure: n/a.
`ifndef DEFINES_SV
`define DEFINES_SV

`define PREG_LENGTH 6
`define PREG_RANGE  `PREG_LENGTH-1:0

`define WB_NSRC     3
`define WB_SRC_ALU  0
`define WB_SRC_MUL  1
`define WB_SRC_LSU  2

`endif

// File: rtl/wb_skid_fifo.sv
// Two-entry result FIFO for one writeback source; head is always entry 0.
// Latency: a push is visible at the head the cycle after the edge that accepts it.
// Backpressure: ready = count < DEPTH, independent of a same-cycle pop.
// Ports: clock/reset_n, clear (sync, dominates push/pop), push + push_entry,
//        pop (caller guarantees head_valid), head_valid + head_entry, ready.
module wb_skid_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
)
(
    input  logic      clock,
    input  logic      reset_n,
    input  logic      clear,
    input  logic      push,
    input  wb_entry_t push_entry,
    input  logic      pop,
    output logic      head_valid,
    output wb_entry_t head_entry,
    output logic      ready
);

    localparam logic [1:0] DEPTH_C = 2'(DEPTH);

    logic [1:0] count;
    wb_entry_t  ent0;
    wb_entry_t  ent1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= 2'd0;
            ent0  <= '0;
            ent1  <= '0;
        end else if (clear) begin
            count <= 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) ent0 <= push_entry;
                    else               ent1 <= push_entry;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    ent0  <= ent1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Count unchanged; the new entry lands behind whatever remains.
                    if (count == 2'd1) begin
                        ent0 <= push_entry;
                    end else begin
                        ent0 <= ent1;
                        ent1 <= push_entry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head_valid = (count != 2'd0);
    assign head_entry = ent0;
    assign ready      = (count < DEPTH_C);

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: buffers ALU/MUL/LSU results and grants up to two per cycle
// round-robin onto the register-file write ports. Latency: 2 cycles valid->write.
// Backpressure: src_ready drops when a source FIFO holds 2 entries or on flush.
// Ports: clock, reset_n (async, active-low), flush, src_valid/src_ready/src_pdst/
//        src_data per source, write{0,1}_{en,idx,data} registered outputs.
// Optional: WB_ARB_PERF_EN adds perf_conflict_cnt and perf_stall_cnt.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int NSRC       = WB_NSRC,
    parameter int FIFO_DEPTH = 2
)
(
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          flush,
    input  logic [NSRC-1:0]               src_valid,
    output logic [NSRC-1:0]               src_ready,
    input  logic [NSRC-1:0][`PREG_RANGE]  src_pdst,
    input  logic [NSRC-1:0][63:0]         src_data,
    output logic                          write0_en,
    output logic [`PREG_RANGE]            write0_idx,
    output logic [63:0]                   write0_data,
    output logic                          write1_en,
    output logic [`PREG_RANGE]            write1_idx,
    output logic [63:0]                   write1_data
`ifdef WB_ARB_PERF_EN
    ,
    output logic [31:0]                   perf_conflict_cnt,
    output logic [31:0]                   perf_stall_cnt
`endif
);

    logic [NSRC-1:0]       fifo_rdy;
    logic [NSRC-1:0]       push;
    logic [NSRC-1:0]       grant;
    logic [NSRC-1:0]       head_vld;
    wb_entry_t [NSRC-1:0]  head;

    logic [1:0] rr_ptr;
    logic [1:0] rr_next;
    logic       g0_vld;
    logic       g1_vld;
    logic [1:0] g0_src;
    logic [1:0] g1_src;

    assign src_ready = fifo_rdy & ~{NSRC{flush}};

    for (genvar s = 0; s < NSRC; s++) begin : g_src
        wb_entry_t entry_in;

        assign entry_in.pdst = src_pdst[s];
        assign entry_in.data = src_data[s];
        // pdst 0 completes the handshake but is dropped on the floor.
        assign push[s] = src_valid[s] && src_ready[s] && (src_pdst[s] != '0);

        wb_skid_fifo #(
            .DEPTH      (FIFO_DEPTH)
        ) u_fifo (
            .clock      (clock),
            .reset_n    (reset_n),
            .clear      (flush),
            .push       (push[s]),
            .push_entry (entry_in),
            .pop        (grant[s]),
            .head_valid (head_vld[s]),
            .head_entry (head[s]),
            .ready      (fifo_rdy[s])
        );
    end

    // Scan from rr_ptr; first eligible head -> port 0, second -> port 1.
    always_comb begin
        logic [1:0] idx;
        grant  = '0;
        g0_vld = 1'b0;
        g1_vld = 1'b0;
        g0_src = 2'd0;
        g1_src = 2'd0;
        idx    = 2'd0;
        if (!flush) begin
            for (int i = 0; i < NSRC; i++) begin
                idx = src_add(rr_ptr, i);
                if (head_vld[idx]) begin
                    if (!g0_vld) begin
                        g0_vld     = 1'b1;
                        g0_src     = idx;
                        grant[idx] = 1'b1;
                    end else if (!g1_vld) begin
                        g1_vld     = 1'b1;
                        g1_src     = idx;
                        grant[idx] = 1'b1;
                    end
                end
            end
        end
        if (g1_vld)      rr_next = src_add(g1_src, 1);
        else if (g0_vld) rr_next = src_add(g0_src, 1);
        else             rr_next = rr_ptr;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr      <= 2'd0;
            write0_en   <= 1'b0;
            write0_idx  <= '0;
            write0_data <= '0;
            write1_en   <= 1'b0;
            write1_idx  <= '0;
            write1_data <= '0;
        end else begin
            rr_ptr    <= rr_next;
            write0_en <= g0_vld;
            write1_en <= g1_vld;
            // Idle ports keep their last idx/data.
            if (g0_vld) begin
                write0_idx  <= head[g0_src].pdst;
                write0_data <= head[g0_src].data;
            end
            if (g1_vld) begin
                write1_idx  <= head[g1_src].pdst;
                write1_data <= head[g1_src].data;
            end
        end
    end

`ifdef WB_ARB_PERF_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_conflict_cnt <= '0;
            perf_stall_cnt    <= '0;
        end else begin
            perf_conflict_cnt <= perf_conflict_cnt + {31'd0, &head_vld};
            perf_stall_cnt    <= perf_stall_cnt + {31'd0, |(src_valid & ~src_ready)};
        end
    end
`endif

endmodule
